// File: rtl/mem_addr_dstb_pkg.sv
// Shared types and constants for the MEM-stage address distributor.
package mem_addr_dstb_pkg;

  localparam logic [1:0] DSTB_RESP_OKAY   = 2'b00;
  localparam logic [1:0] DSTB_RESP_SLVERR = 2'b10;
  localparam logic [1:0] DSTB_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } dstb_state_e;

  // $clog2 that never yields a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_addr_dstb_decoder.sv
// Priority window decoder: a target hits when (addr & MASK_i) == BASE_i,
// and the lowest matching index wins.
module mem_addr_dstb_decoder
  import mem_addr_dstb_pkg::*;
#(
  parameter int NUM_SLV = 2,
  parameter int ADDR_W  = 64,
  parameter int IDX_W   = clog2_min1(NUM_SLV),
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
)(
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Scanning downward lets the lowest index overwrite any higher match.
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_addr_dstb.sv
// N-target address distributor: decodes a MEM-stage request, forwards it to one
// target, waits for ready (or timeout) and returns data/response/skip to the master.
module mem_addr_dstb
  import mem_addr_dstb_pkg::*;
#(
  parameter int NUM_SLV = 2,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {64'h0200_0000, 64'h8000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {64'hFFFF_0000, 64'h8000_0000},
  parameter logic [NUM_SLV-1:0]        SKIP_VEC = 2'b10,
  parameter int TIMEOUT = 255
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dstb_valid_i,
  input  logic                      dstb_req_i,
  input  logic [ADDR_W-1:0]         dstb_addr_i,
  input  logic [1:0]                dstb_size_i,
  input  logic [DATA_W-1:0]         dstb_data_write_i,
  output logic                      dstb_ready_o,
  output logic [DATA_W-1:0]         dstb_data_read_o,
  output logic [1:0]                dstb_resp_o,
  output logic                      dstb_skip_o,
  output logic [NUM_SLV-1:0]        slv_valid_o,
  output logic                      slv_req_o,
  output logic [ADDR_W-1:0]         slv_addr_o,
  output logic [1:0]                slv_size_o,
  output logic [DATA_W-1:0]         slv_data_write_o,
  input  logic [NUM_SLV-1:0]        slv_ready_i,
  input  logic [NUM_SLV*DATA_W-1:0] slv_data_read_i,
  input  logic [NUM_SLV*2-1:0]      slv_resp_i
);

  localparam int IDX_W = clog2_min1(NUM_SLV);
  localparam int CNT_W = clog2_min1(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  dstb_state_e        state, state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               sel_ready;
  logic [DATA_W-1:0]  sel_rdata;
  logic [1:0]         sel_resp;
  logic               sel_skip;
  logic               timeout_hit;

  mem_addr_dstb_decoder #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .addr (dstb_addr_i),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the latched target's ready/data/resp are ever observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    sel_resp  = DSTB_RESP_OKAY;
    sel_skip  = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = slv_ready_i[i];
        sel_rdata = slv_data_read_i[i*DATA_W +: DATA_W];
        sel_resp  = slv_resp_i[i*2 +: 2];
        sel_skip  = SKIP_VEC[i];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TMO);

  always_comb begin
    slv_valid_o = '0;
    if (state == ST_BUSY) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (idx_q == IDX_W'(i)) slv_valid_o[i] = 1'b1;
      end
    end
  end

  assign dstb_ready_o = (state == ST_DONE) || (state == ST_ERR);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (dstb_valid_i) state_nxt = dec_hit ? ST_BUSY : ST_ERR;
      ST_BUSY: if (sel_ready || timeout_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      idx_q            <= '0;
      cnt              <= '0;
      slv_req_o        <= 1'b0;
      slv_addr_o       <= '0;
      slv_size_o       <= 2'b00;
      slv_data_write_o <= '0;
      dstb_data_read_o <= '0;
      dstb_resp_o      <= DSTB_RESP_OKAY;
      dstb_skip_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (dstb_valid_i) begin
            slv_req_o        <= dstb_req_i;
            slv_addr_o       <= dstb_addr_i;
            slv_size_o       <= dstb_size_i;
            slv_data_write_o <= dstb_data_write_i;
            idx_q            <= dec_idx;
            cnt              <= '0;
            if (!dec_hit) begin
              dstb_data_read_o <= '0;
              dstb_resp_o      <= DSTB_RESP_DECERR;
              dstb_skip_o      <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          // Ready takes precedence over a timeout in the same cycle.
          if (sel_ready) begin
            dstb_data_read_o <= sel_rdata;
            dstb_resp_o      <= sel_resp;
            dstb_skip_o      <= sel_skip;
          end else if (timeout_hit) begin
            dstb_data_read_o <= '0;
            dstb_resp_o      <= DSTB_RESP_SLVERR;
            dstb_skip_o      <= sel_skip;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_dstb.sv
// Directed bench for mem_addr_dstb: three targets (0 and 2 overlap), TIMEOUT = 4.
module tb_mem_addr_dstb;

  logic          clk;
  logic          rst;
  logic          dstb_valid;
  logic          dstb_req;
  logic [63:0]   dstb_addr;
  logic [1:0]    dstb_size;
  logic [63:0]   dstb_data_write;
  logic          dstb_ready;
  logic [63:0]   dstb_data_read;
  logic [1:0]    dstb_resp;
  logic          dstb_skip;
  logic [2:0]    slv_valid;
  logic          slv_req;
  logic [63:0]   slv_addr;
  logic [1:0]    slv_size;
  logic [63:0]   slv_data_write;
  logic [2:0]    slv_ready;
  logic [191:0]  slv_data_read;
  logic [5:0]    slv_resp;

  int checks = 0;
  int errors = 0;

  mem_addr_dstb #(
    .NUM_SLV  (3),
    .DATA_W   (64),
    .ADDR_W   (64),
    .SLV_BASE ({64'h8000_0000, 64'h0200_0000, 64'h8000_0000}),
    .SLV_MASK ({64'hFFFF_0000, 64'hFFFF_0000, 64'h8000_0000}),
    .SKIP_VEC (3'b110),
    .TIMEOUT  (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .dstb_valid_i      (dstb_valid),
    .dstb_req_i        (dstb_req),
    .dstb_addr_i       (dstb_addr),
    .dstb_size_i       (dstb_size),
    .dstb_data_write_i (dstb_data_write),
    .dstb_ready_o      (dstb_ready),
    .dstb_data_read_o  (dstb_data_read),
    .dstb_resp_o       (dstb_resp),
    .dstb_skip_o       (dstb_skip),
    .slv_valid_o       (slv_valid),
    .slv_req_o         (slv_req),
    .slv_addr_o        (slv_addr),
    .slv_size_o        (slv_size),
    .slv_data_write_o  (slv_data_write),
    .slv_ready_i       (slv_ready),
    .slv_data_read_i   (slv_data_read),
    .slv_resp_i        (slv_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    int          wait_cyc;   // target raises ready in valid cycle wait_cyc+1
    logic [2:0]  rdy_mask;   // ready bits driven in that cycle
    logic        drop;       // master drops valid right after accept
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [5:0]  rsp;
    logic [2:0]  exp_sel;
    int          exp_vcnt;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_skip;
    int          exp_cycles; // cycles with the request outstanding, accept cycle included
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs[NVEC];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int lat, vcnt;
    logic got, shared_ok, onehot_ok;
    logic [2:0] seen;
    logic [63:0] d;
    logic [1:0] r;
    logic s;
    @(negedge clk);
    dstb_valid      = 1'b1;
    dstb_req        = v.wr;
    dstb_addr       = v.addr;
    dstb_size       = v.size;
    dstb_data_write = v.wdata;
    slv_data_read   = {v.rd2, v.rd1, v.rd0};
    slv_resp        = v.rsp;
    slv_ready       = 3'b000;
    lat = 0; vcnt = 0; got = 1'b0; shared_ok = 1'b1; onehot_ok = 1'b1;
    seen = 3'b000; d = '0; r = 2'b00; s = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        if (v.drop) dstb_valid = 1'b0;
        if (slv_req !== v.wr || slv_addr !== v.addr || slv_size !== v.size ||
            slv_data_write !== v.wdata) shared_ok = 1'b0;
      end
      if (dstb_ready) begin
        got = 1'b1; d = dstb_data_read; r = dstb_resp; s = dstb_skip;
        dstb_valid = 1'b0;
      end
      if (slv_valid != 3'b000) begin
        vcnt++;
        seen |= slv_valid;
        if (slv_valid !== v.exp_sel) onehot_ok = 1'b0;
        if (slv_req !== v.wr || slv_addr !== v.addr || slv_size !== v.size ||
            slv_data_write !== v.wdata) shared_ok = 1'b0;
        slv_ready = (vcnt - 1 == v.wait_cyc) ? v.rdy_mask : 3'b000;
      end else begin
        slv_ready = 3'b000;
      end
    end
    dstb_valid = 1'b0;
    check({tag, ".done"},    64'(got), 64'd1);
    check({tag, ".sel"},     64'(seen), 64'(v.exp_sel));
    check({tag, ".onehot"},  64'(onehot_ok), 64'd1);
    check({tag, ".vcnt"},    64'(vcnt), 64'(v.exp_vcnt));
    check({tag, ".shared"},  64'(shared_ok), 64'd1);
    check({tag, ".cycles"},  64'(lat + 1), 64'(v.exp_cycles));
    check({tag, ".data"},    d, v.exp_data);
    check({tag, ".resp"},    64'(r), 64'(v.exp_resp));
    check({tag, ".skip"},    64'(s), 64'(v.exp_skip));
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, 64'({dstb_ready, slv_valid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            wr    addr              sz     wdata      wait rdy     drop  rd0                     rd1       rd2       rsp        sel     vcnt data                    resp   skip  cyc
    vecs[0] = '{1'b0, 64'h8000_1000, 2'd2, 64'h0,     2,  3'b001, 1'b0, 64'hDEAD_BEEF,          64'h1111, 64'h2222, 6'b000000, 3'b001, 3, 64'hDEAD_BEEF,          2'b00, 1'b0, 5};
    vecs[1] = '{1'b1, 64'h0200_4000, 2'd3, 64'h55,    0,  3'b010, 1'b0, 64'hAAAA,               64'h1234, 64'h0,    6'b000000, 3'b010, 1, 64'h1234,               2'b00, 1'b1, 3};
    vecs[2] = '{1'b0, 64'h1000_0000, 2'd2, 64'h0,     0,  3'b111, 1'b0, 64'hAAAA,               64'hBBBB, 64'hCCCC, 6'b000000, 3'b000, 0, 64'h0,                  2'b11, 1'b0, 2};
    vecs[3] = '{1'b0, 64'h8000_2000, 2'd3, 64'h0,     99, 3'b001, 1'b0, 64'hFFFF,               64'h0,    64'h0,    6'b000000, 3'b001, 5, 64'h0,                  2'b10, 1'b0, 7};
    vecs[4] = '{1'b0, 64'h8000_0008, 2'd3, 64'h0,     0,  3'b111, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1,   64'h2,    6'b111000, 3'b001, 1, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0, 3};
    vecs[5] = '{1'b0, 64'h8000_3000, 2'd2, 64'h0,     0,  3'b110, 1'b0, 64'h9999,               64'h1,    64'h2,    6'b000000, 3'b001, 5, 64'h0,                  2'b10, 1'b0, 7};
    vecs[6] = '{1'b0, 64'h8000_4000, 2'd2, 64'h0,     4,  3'b001, 1'b0, 64'hCAFE,               64'h0,    64'h0,    6'b000000, 3'b001, 5, 64'hCAFE,               2'b00, 1'b0, 7};
    vecs[7] = '{1'b0, 64'h0200_0010, 2'd1, 64'h0,     1,  3'b010, 1'b0, 64'h0,                  64'hBEEF, 64'h0,    6'b001000, 3'b010, 2, 64'hBEEF,               2'b10, 1'b1, 4};
    vecs[8] = '{1'b1, 64'h8000_0100, 2'd0, 64'hA5,    1,  3'b001, 1'b1, 64'h77,                 64'h0,    64'h0,    6'b000000, 3'b001, 2, 64'h77,                 2'b00, 1'b0, 4};

    rst = 1'b1;
    dstb_valid = 1'b0; dstb_req = 1'b0; dstb_addr = '0; dstb_size = 2'b00;
    dstb_data_write = '0; slv_ready = 3'b000; slv_data_read = '0; slv_resp = '0;
    #1;
    check("reset.ctrl", 64'({dstb_ready, slv_valid, dstb_skip, dstb_resp}), 64'd0);
    check("reset.data", dstb_data_read | slv_addr | slv_data_write, 64'd0);
    check("reset.req",  64'({slv_req, slv_size}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) run_txn($sformatf("v%0d", k), vecs[k]);

    // Reset pulsed while a target access is in flight.
    @(negedge clk);
    dstb_valid = 1'b1; dstb_req = 1'b0; dstb_addr = 64'h8000_5000; dstb_size = 2'd3;
    slv_ready = 3'b000;
    @(posedge clk); #1;
    check("rstmid.busy", 64'(slv_valid), 64'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid.ctrl", 64'({dstb_ready, slv_valid, dstb_resp, dstb_skip}), 64'd0);
    check("rstmid.addr", slv_addr, 64'd0);
    dstb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid.quiet%0d", c), 64'({dstb_ready, slv_valid}), 64'd0);
    end
    run_txn("rstmid.next", vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
